eth_rx_dispatcher: RTL and testbench

Receive-side frame dispatcher in the Ethernet RX path. It runs beside the header-cutting datapath on the same byte stream and counts the 14 header bytes itself. At the first payload byte it samples that datapath's MAC and EtherType classification and applies a destination-MAC filter. It then steers the payload to the IP consumer, the ARP consumer, or drops the frame, with optional frame statistics.

---
 rtl/eth_pkg.sv | 36 +++
 rtl/eth_rx_stats.sv | 43 ++++
 rtl/eth_rx_dispatcher.sv | 178 +++++++++++++++++
 tb/tb_eth_rx_dispatcher.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet RX dispatch path.
package eth_pkg;

  localparam int          ETH_HDR_LEN = 14;
  localparam logic [47:0] MAC_BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETYPE_IP    = 16'h0800;
  localparam logic [15:0] ETYPE_ARP   = 16'h0806;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FWD_IP,
    ST_FWD_ARP,
    ST_DROP
  } rx_state_e;

  typedef enum logic [1:0] {
    DEC_DROP,
    DEC_IP,
    DEC_ARP
  } rx_dec_e;

  // Frame steering decision; filter failures and invalid EtherTypes outrank everything.
  function automatic rx_dec_e classify(input logic mac_ok,
                                       input logic is_ip,
                                       input logic is_arp,
                                       input logic is_invalid,
                                       input logic ip_busy,
                                       input logic arp_busy);
    if (is_invalid || !mac_ok) return DEC_DROP;
    if (is_ip)                 return ip_busy ? DEC_DROP : DEC_IP;
    if (is_arp)                return arp_busy ? DEC_DROP : DEC_ARP;
    return DEC_DROP;
  endfunction

endpackage

// File: rtl/eth_rx_stats.sv
// Saturating frame statistics counters (ip / arp / drop / runt) with synchronous clear.
module eth_rx_stats
  import eth_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              stat_clr,
  input  logic              inc_ip,
  input  logic              inc_arp,
  input  logic              inc_drop,
  input  logic              inc_runt,
  output logic [STAT_W-1:0] stat_ip,
  output logic [STAT_W-1:0] stat_arp,
  output logic [STAT_W-1:0] stat_drop,
  output logic [STAT_W-1:0] stat_runt
);

  logic [3:0]        w_inc;
  logic [STAT_W-1:0] r_cnt [4];

  assign w_inc = {inc_runt, inc_drop, inc_arp, inc_ip};

  // NOTE: this small array is software-visible state, so it is reset like any register.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else if (stat_clr) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_inc[k] && (r_cnt[k] != '1)) r_cnt[k] <= r_cnt[k] + STAT_W'(1);
      end
    end
  end

  assign stat_ip   = r_cnt[0];
  assign stat_arp  = r_cnt[1];
  assign stat_drop = r_cnt[2];
  assign stat_runt = r_cnt[3];

endmodule

// File: rtl/eth_rx_dispatcher.sv
// Ethernet RX dispatcher: counts header bytes, filters on destination MAC and steers payload.
// Define ETH_RX_STATS_EN to add the stat_* counters and the stat_clr input.
module eth_rx_dispatcher
  import eth_pkg::*;
#(
  parameter int HDR_LEN = ETH_HDR_LEN,
  parameter int STAT_W  = 16
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic [47:0]       my_mac,
  input  logic [7:0]        datain,
  input  logic              data_en,
  input  logic [47:0]       board_mac,
  input  logic              is_ip,
  input  logic              is_arp,
  input  logic              is_invalid,
  input  logic              ip_busy,
  input  logic              arp_busy,
  output logic [7:0]        ip_data,
  output logic [7:0]        arp_data,
  output logic              ip_en,
  output logic              arp_en,
  output logic              ip_sop,
  output logic              arp_sop,
  output logic              ip_done,
  output logic              arp_done,
  output logic              busy
`ifdef ETH_RX_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_ip,
  output logic [STAT_W-1:0] stat_arp,
  output logic [STAT_W-1:0] stat_drop,
  output logic [STAT_W-1:0] stat_runt
`endif
);

  localparam int CNT_W = $clog2(HDR_LEN + 1);

  if (HDR_LEN < 1 || STAT_W < 1) begin : g_param_check
    $error("eth_rx_dispatcher: HDR_LEN and STAT_W must be at least 1");
  end

  rx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_mac_ok, w_decide;
  rx_dec_e          w_dec;

  logic [7:0] r_ip_data, r_arp_data, w_ip_data_nxt, w_arp_data_nxt;
  logic       r_ip_en, r_arp_en, r_ip_sop, r_arp_sop, r_ip_done, r_arp_done, r_busy;
  logic       w_ip_en_nxt, w_arp_en_nxt, w_ip_sop_nxt, w_arp_sop_nxt;
  logic       w_ip_done_nxt, w_arp_done_nxt, w_busy_nxt;

  assign w_mac_ok = (board_mac == my_mac) || (board_mac == MAC_BCAST);
  assign w_decide = (r_state == ST_HDR) && data_en && (r_cnt == CNT_W'(HDR_LEN));
  assign w_dec    = classify(w_mac_ok, is_ip, is_arp, is_invalid, ip_busy, arp_busy);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: defaults first, so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (data_en) begin
          w_state_nxt = ST_HDR;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_HDR: begin
        if (!data_en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_decide) begin
          // Counter holds at HDR_LEN for the rest of the frame.
          unique case (w_dec)
            DEC_IP:  w_state_nxt = ST_FWD_IP;
            DEC_ARP: w_state_nxt = ST_FWD_ARP;
            default: w_state_nxt = ST_DROP;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_FWD_IP, ST_FWD_ARP, ST_DROP: begin
        if (!data_en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_ip_sop_nxt   = w_decide && (w_dec == DEC_IP);
    w_arp_sop_nxt  = w_decide && (w_dec == DEC_ARP);
    w_ip_en_nxt    = w_ip_sop_nxt  || (data_en && (r_state == ST_FWD_IP));
    w_arp_en_nxt   = w_arp_sop_nxt || (data_en && (r_state == ST_FWD_ARP));
    w_ip_done_nxt  = !data_en && (r_state == ST_FWD_IP);
    w_arp_done_nxt = !data_en && (r_state == ST_FWD_ARP);
    w_ip_data_nxt  = w_ip_en_nxt  ? datain : r_ip_data;
    w_arp_data_nxt = w_arp_en_nxt ? datain : r_arp_data;
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_ip_data  <= '0;
      r_arp_data <= '0;
      r_ip_en    <= 1'b0;
      r_arp_en   <= 1'b0;
      r_ip_sop   <= 1'b0;
      r_arp_sop  <= 1'b0;
      r_ip_done  <= 1'b0;
      r_arp_done <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ip_data  <= w_ip_data_nxt;
      r_arp_data <= w_arp_data_nxt;
      r_ip_en    <= w_ip_en_nxt;
      r_arp_en   <= w_arp_en_nxt;
      r_ip_sop   <= w_ip_sop_nxt;
      r_arp_sop  <= w_arp_sop_nxt;
      r_ip_done  <= w_ip_done_nxt;
      r_arp_done <= w_arp_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign ip_data  = r_ip_data;
  assign arp_data = r_arp_data;
  assign ip_en    = r_ip_en;
  assign arp_en   = r_arp_en;
  assign ip_sop   = r_ip_sop;
  assign arp_sop  = r_arp_sop;
  assign ip_done  = r_ip_done;
  assign arp_done = r_arp_done;
  assign busy     = r_busy;

`ifdef ETH_RX_STATS_EN
  logic w_inc_drop, w_inc_runt;

  assign w_inc_drop = w_decide && (w_dec == DEC_DROP);
  assign w_inc_runt = (r_state == ST_HDR) && !data_en;

  eth_rx_stats #(
    .STAT_W(STAT_W)
  ) u_stats (
    .clock    (clock),
    .aclr     (aclr),
    .stat_clr (stat_clr),
    .inc_ip   (w_ip_sop_nxt),
    .inc_arp  (w_arp_sop_nxt),
    .inc_drop (w_inc_drop),
    .inc_runt (w_inc_runt),
    .stat_ip  (stat_ip),
    .stat_arp (stat_arp),
    .stat_drop(stat_drop),
    .stat_runt(stat_runt)
  );
`endif

endmodule

// File: tb/tb_eth_rx_dispatcher.sv
// Scoreboard bench for eth_rx_dispatcher: frame-level reference model feeds per-channel queues.
// Build with ETH_RX_STATS_EN defined to also exercise the statistics counters.
module tb_eth_rx_dispatcher;
  import eth_pkg::*;

  localparam int          STAT_W   = 4;
  localparam logic [47:0] MY_MAC   = 48'h02_00_00_00_00_01;
  localparam int          CLS_IP   = 0;
  localparam int          CLS_ARP  = 1;
  localparam int          CLS_INV  = 2;
  localparam int          CLS_NONE = 3;

  typedef struct packed {
    logic       done;
    logic       sop;
    logic [7:0] data;
  } exp_t;

  logic        clock, aclr;
  logic [47:0] my_mac, board_mac;
  logic [7:0]  datain, ip_data, arp_data;
  logic        data_en, is_ip, is_arp, is_invalid, ip_busy, arp_busy;
  logic        ip_en, arp_en, ip_sop, arp_sop, ip_done, arp_done, busy;
`ifdef ETH_RX_STATS_EN
  logic              stat_clr;
  logic [STAT_W-1:0] stat_ip, stat_arp, stat_drop, stat_runt;
`endif

  exp_t ip_q[$];
  exp_t arp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_ip = 0, m_arp = 0, m_drop = 0, m_runt = 0;

  eth_rx_dispatcher #(
    .HDR_LEN(ETH_HDR_LEN),
    .STAT_W (STAT_W)
  ) dut (
    .clock     (clock),
    .aclr      (aclr),
    .my_mac    (my_mac),
    .datain    (datain),
    .data_en   (data_en),
    .board_mac (board_mac),
    .is_ip     (is_ip),
    .is_arp    (is_arp),
    .is_invalid(is_invalid),
    .ip_busy   (ip_busy),
    .arp_busy  (arp_busy),
    .ip_data   (ip_data),
    .arp_data  (arp_data),
    .ip_en     (ip_en),
    .arp_en    (arp_en),
    .ip_sop    (ip_sop),
    .arp_sop   (arp_sop),
    .ip_done   (ip_done),
    .arp_done  (arp_done),
    .busy      (busy)
`ifdef ETH_RX_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_ip   (stat_ip),
    .stat_arp  (stat_arp),
    .stat_drop (stat_drop),
    .stat_runt (stat_runt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > (1 << STAT_W) - 1) ? (1 << STAT_W) - 1 : v;
  endfunction

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  // Pops one expected entry per observed byte or done pulse on a channel.
  task automatic mon_chan(input int ch, input logic en, input logic sop, input logic done,
                          input logic [7:0] data);
    exp_t  e;
    string nm;
    bit    empty;
    nm = (ch == 0) ? "ip" : "arp";
    if (!en && sop) check({nm, "_sop_without_en"}, 64'(sop), 64'd0);
    if (en || done) begin
      empty = (ch == 0) ? (ip_q.size() == 0) : (arp_q.size() == 0);
      if (empty) begin
        total++;
        bad++;
        $display("FAIL %s_unexpected: en=%0b done=%0b data=%02h, nothing expected", nm, en, done, data);
      end else begin
        if (ch == 0) e = ip_q.pop_front();
        else         e = arp_q.pop_front();
        check({nm, "_kind"}, 64'({en, done}), 64'({~e.done, e.done}));
        if (en && !e.done) begin
          check({nm, "_data"}, 64'(data), 64'(e.data));
          check({nm, "_sop"}, 64'(sop), 64'(e.sop));
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (!aclr) begin
      if (ip_en || arp_en) check("single_en", 64'(ip_en && arp_en), 64'd0);
      mon_chan(0, ip_en, ip_sop, ip_done, ip_data);
      mon_chan(1, arp_en, arp_sop, arp_done, arp_data);
    end
  end

  // Builds a frame, pushes the model's expectation, then drives it byte by byte.
  task automatic send_frame(input logic [47:0] dst, input int cls, input bit busy_dec,
                            input int len, input bit ramp, input int gap, input int abort_at);
    logic [7:0]  b[$];
    logic [15:0] et;
    bit          mac_ok;
    int          dest, last;
    case (cls)
      CLS_IP:  et = ETYPE_IP;
      CLS_ARP: et = ETYPE_ARP;
      CLS_INV: et = 16'h86DD;
      default: et = 16'h88B5;
    endcase
    for (int i = 0; i < len; i++) begin
      logic [7:0] v;
      if (i < 6)                          v = dst[47-8*i -: 8];
      else if (i == 12)                   v = et[15:8];
      else if (i == 13)                   v = et[7:0];
      else if (i >= ETH_HDR_LEN && ramp)  v = 8'(i - ETH_HDR_LEN);
      else                                v = 8'($urandom);
      b.push_back(v);
    end
    last = (abort_at >= 0) ? ETH_HDR_LEN + abort_at : len - 1;

    if (len <= ETH_HDR_LEN) begin
      m_runt++;
    end else begin
      mac_ok = (dst == MY_MAC) || (dst == MAC_BCAST);
      if (cls == CLS_INV || !mac_ok) dest = 0;
      else if (cls == CLS_IP)        dest = busy_dec ? 0 : 1;
      else if (cls == CLS_ARP)       dest = busy_dec ? 0 : 2;
      else                           dest = 0;
      if (dest == 0) m_drop++;
      if (dest == 1) m_ip++;
      if (dest == 2) m_arp++;
      for (int k = ETH_HDR_LEN; k <= last; k++) begin
        if (dest == 1) ip_q.push_back('{done: 1'b0, sop: (k == ETH_HDR_LEN), data: b[k]});
        if (dest == 2) arp_q.push_back('{done: 1'b0, sop: (k == ETH_HDR_LEN), data: b[k]});
      end
      if (abort_at < 0 && dest == 1) ip_q.push_back('{done: 1'b1, sop: 1'b0, data: 8'h00});
      if (abort_at < 0 && dest == 2) arp_q.push_back('{done: 1'b1, sop: 1'b0, data: 8'h00});
    end

    for (int i = 0; i <= last; i++) begin
      datain    = b[i];
      data_en   = 1'b1;
      board_mac = (i >= 6) ? dst : rand48();
      if (i >= ETH_HDR_LEN) begin
        is_ip      = (cls == CLS_IP);
        is_arp     = (cls == CLS_ARP);
        is_invalid = (cls == CLS_INV);
      end else begin
        is_ip      = 1'($urandom);
        is_arp     = 1'($urandom);
        is_invalid = 1'($urandom);
      end
      ip_busy  = (i == ETH_HDR_LEN && cls == CLS_IP)  ? busy_dec : 1'($urandom);
      arp_busy = (i == ETH_HDR_LEN && cls == CLS_ARP) ? busy_dec : 1'($urandom);
      @(posedge clock);
      #1;
    end
    if (abort_at < 0) begin
      data_en = 1'b0;
      datain  = 8'($urandom);
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (ip_q.size() != 0 || arp_q.size() != 0); c++) begin
      @(posedge clock);
      #1;
    end
    check("drain_ip_q", 64'(ip_q.size()), 64'd0);
    check("drain_arp_q", 64'(arp_q.size()), 64'd0);
  endtask

  task automatic check_stats();
`ifdef ETH_RX_STATS_EN
    check("stat_ip", 64'(stat_ip), 64'(sat(m_ip)));
    check("stat_arp", 64'(stat_arp), 64'(sat(m_arp)));
    check("stat_drop", 64'(stat_drop), 64'(sat(m_drop)));
    check("stat_runt", 64'(stat_runt), 64'(sat(m_runt)));
`endif
  endtask

  initial begin
    my_mac     = MY_MAC;
    aclr       = 1'b1;
    datain     = '0;
    data_en    = 1'b0;
    board_mac  = '0;
    is_ip      = 1'b0;
    is_arp     = 1'b0;
    is_invalid = 1'b0;
    ip_busy    = 1'b0;
    arp_busy   = 1'b0;
`ifdef ETH_RX_STATS_EN
    stat_clr   = 1'b0;
`endif
    #12;
    check("rst_ip_en", 64'(ip_en), 64'd0);
    check("rst_arp_en", 64'(arp_en), 64'd0);
    check("rst_ip_sop", 64'(ip_sop), 64'd0);
    check("rst_arp_sop", 64'(arp_sop), 64'd0);
    check("rst_ip_done", 64'(ip_done), 64'd0);
    check("rst_arp_done", 64'(arp_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ip_data", 64'(ip_data), 64'd0);
    check("rst_arp_data", 64'(arp_data), 64'd0);
    check_stats();
    @(posedge clock);
    #1;
    aclr = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end

    // Directed scenarios
    send_frame(MY_MAC, CLS_IP, 1'b0, 34, 1'b1, 2, -1);
    send_frame(MAC_BCAST, CLS_ARP, 1'b0, 42, 1'b0, 2, -1);
    send_frame(48'h02_00_00_00_00_02, CLS_IP, 1'b0, 30, 1'b0, 1, -1);
    send_frame(MY_MAC, CLS_IP, 1'b0, 25, 1'b0, 2, -1);
    send_frame(MY_MAC, CLS_IP, 1'b1, 30, 1'b0, 2, -1);
    send_frame(MY_MAC, CLS_ARP, 1'b1, 30, 1'b0, 1, -1);
    send_frame(MY_MAC, CLS_INV, 1'b0, 30, 1'b0, 2, -1);
    send_frame(MY_MAC, CLS_NONE, 1'b0, 30, 1'b0, 1, -1);
    send_frame(MY_MAC, CLS_IP, 1'b0, 10, 1'b0, 1, -1);
    send_frame(MY_MAC, CLS_IP, 1'b0, 20, 1'b1, 1, -1);
    send_frame(MY_MAC, CLS_IP, 1'b0, 14, 1'b0, 1, -1);
    send_frame(MY_MAC, CLS_IP, 1'b0, 15, 1'b0, 1, -1);
    send_frame(MAC_BCAST, CLS_ARP, 1'b0, 15, 1'b0, 1, -1);
    drain();
    check_stats();

    // Randomized frames
    for (int n = 0; n < 60; n++) begin
      logic [47:0] dst;
      int          sel;
      sel = $urandom_range(0, 2);
      dst = (sel == 0) ? MY_MAC : (sel == 1) ? MAC_BCAST : {8'h0A, 40'({$urandom(), $urandom()})};
      send_frame(dst, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(1, 40),
                 1'b0, $urandom_range(1, 3), -1);
    end
    drain();
    check_stats();

    // Asynchronous reset while payload byte 5 of an IP frame is on the output
    send_frame(MY_MAC, CLS_IP, 1'b0, 40, 1'b1, 0, 5);
    check("pre_reset_ip_en", 64'(ip_en), 64'd1);
    #6;
    aclr = 1'b1;
    #1;
    check("async_rst_ip_en", 64'(ip_en), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_ip_sop", 64'(ip_sop), 64'd0);
    data_en = 1'b0;
    m_ip = 0; m_arp = 0; m_drop = 0; m_runt = 0;
    @(posedge clock);
    #1;
    aclr = 1'b0;
    check_stats();
    send_frame(MAC_BCAST, CLS_ARP, 1'b0, 30, 1'b0, 2, -1);
    drain();

`ifdef ETH_RX_STATS_EN
    stat_clr = 1'b1;
    @(posedge clock);
    #1;
    stat_clr = 1'b0;
    m_ip = 0; m_arp = 0; m_drop = 0; m_runt = 0;
    check_stats();
`endif

    // Saturation: more IP frames than a 4-bit counter can hold
    for (int n = 0; n < 17; n++) send_frame(MY_MAC, CLS_IP, 1'b0, $urandom_range(15, 22), 1'b0, 1, -1);
    drain();
    check_stats();
    check("final_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
